// File: rtl/comparator_seq_if.sv
// Start/operand/result bundle between a requester and comparator_seq.
// The master drives the request and operands; the slave returns the handshake and flags.
interface comparator_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             cs_cmp;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             ready;
   logic             done;
   logic             cout;
   logic             z_flag;
   logic             lt_flag;

   modport master (
      output cs_cmp, a, b, signed_mode,
      input  ready, done, cout, z_flag, lt_flag
   );

   modport slave (
      input  cs_cmp, a, b, signed_mode,
      output ready, done, cout, z_flag, lt_flag
   );
endinterface

// File: rtl/comparator_seq.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle.
// Signed compares flip both operand MSBs at capture and then run unsigned.
module comparator_seq #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DIGIT      = 1,
   parameter bit          EARLY_EXIT = 1'b0
) (
   input logic              clk,
   input logic              rst,
   comparator_seq_if.slave  bus
);
   localparam int unsigned NSLICE = WIDTH / DIGIT;
   localparam int unsigned JW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;
   typedef enum logic [1:0] {R_EQ, R_GT, R_LT} res_t;

   state_t           state_q, state_d;
   res_t             res_q, res_d, res_next;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [JW-1:0]    j_q, j_d;
   logic             ready_q, ready_d, done_q, done_d;
   logic             cout_q, cout_d, z_q, z_d, lt_q, lt_d;
   logic [DIGIT-1:0] slice_a, slice_b;
   logic             slice_ne;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         res_q   <= R_EQ;
         a_q     <= '0;
         b_q     <= '0;
         j_q     <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         z_q     <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         a_q     <= a_d;
         b_q     <= b_d;
         j_q     <= j_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
         z_q     <= z_d;
         lt_q    <= lt_d;
      end
   end

   // Operands shift left each COMPARE cycle, so slice j is always the top DIGIT bits.
   always_comb begin
      state_d  = state_q;
      res_d    = res_q;
      a_d      = a_q;
      b_d      = b_q;
      j_d      = j_q;
      cout_d   = cout_q;
      z_d      = z_q;
      lt_d     = lt_q;
      slice_a  = a_q[WIDTH-1 -: DIGIT];
      slice_b  = b_q[WIDTH-1 -: DIGIT];
      slice_ne = (slice_a != slice_b);
      res_next = res_q;
      if (res_q == R_EQ && slice_ne) begin
         res_next = (slice_a > slice_b) ? R_GT : R_LT;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.cs_cmp) begin
               a_d     = bus.a ^ (bus.signed_mode ? MSB_MASK : '0);
               b_d     = bus.b ^ (bus.signed_mode ? MSB_MASK : '0);
               j_d     = '0;
               res_d   = R_EQ;
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            res_d = res_next;
            a_d   = a_q << DIGIT;
            b_d   = b_q << DIGIT;
            j_d   = j_q + JW'(1);
            if ((EARLY_EXIT && slice_ne) || (j_q == JW'(NSLICE - 1))) begin
               state_d = S_DONE;
               cout_d  = (res_next == R_GT);
               z_d     = (res_next == R_EQ);
               lt_d    = (res_next == R_LT);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   assign bus.ready   = ready_q;
   assign bus.done    = done_q;
   assign bus.cout    = cout_q;
   assign bus.z_flag  = z_q;
   assign bus.lt_flag = lt_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Drives two comparator_seq instances (WIDTH=8, DIGIT=2, EARLY_EXIT 0 and 1) with identical
// stimulus and checks latency, handshake and flags against a behavioural model.
module tb_comparator_seq;
   localparam int unsigned W  = 8;
   localparam int unsigned DG = 2;
   localparam int unsigned NS = W / DG;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   comparator_seq_if #(.WIDTH(W)) if0 ();
   comparator_seq_if #(.WIDTH(W)) if1 ();

   comparator_seq #(.WIDTH(W), .DIGIT(DG), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   comparator_seq #(.WIDTH(W), .DIGIT(DG), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   // result code: 0 = equal, 1 = a>b, 2 = a<b
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sm;
      int         res;
      int         lat_ee;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] ta, input logic [7:0] tb_, input logic tsm, input logic cs);
      if0.a = ta; if0.b = tb_; if0.signed_mode = tsm; if0.cs_cmp = cs;
      if1.a = ta; if1.b = tb_; if1.signed_mode = tsm; if1.cs_cmp = cs;
   endtask

   function automatic logic [2:0] flags_of(input int res);
      return {res == 1, res == 0, res == 2};
   endfunction

   function automatic int model_res(input logic [7:0] ta, input logic [7:0] tb_, input logic tsm);
      int va, vb;
      va = tsm ? int'($signed(ta)) : int'(ta);
      vb = tsm ? int'($signed(tb_)) : int'(tb_);
      if (va > vb) return 1;
      if (va < vb) return 2;
      return 0;
   endfunction

   function automatic int model_lat(input logic [7:0] ta, input logic [7:0] tb_, input bit ee);
      int sa, sb;
      if (!ee) return NS;
      for (int j = 0; j < NS; j++) begin
         sa = (int'(ta) >> (W - (j + 1) * DG)) & 3;
         sb = (int'(tb_) >> (W - (j + 1) * DG)) & 3;
         if (sa != sb) return j + 1;
      end
      return NS;
   endfunction

   function automatic logic [4:0] outs(input int d);
      if (d == 0) return {if0.ready, if0.done, if0.cout, if0.z_flag, if0.lt_flag};
      return {if1.ready, if1.done, if1.cout, if1.z_flag, if1.lt_flag};
   endfunction

   // One compare on both instances: capture edge, then NS+1 observed cycles.
   task automatic run_cmp(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tsm, input int res, input int lat1);
      logic [4:0] o [2][NS+2];
      int first, ndone, lat;
      drive(ta, tb_, tsm, 1'b1);
      tick();
      drive(ta, tb_, tsm, 1'b0);
      chk({nm, " ready_low0"}, 32'(if0.ready), 32'd0);
      chk({nm, " ready_low1"}, 32'(if1.ready), 32'd0);
      for (int c = 1; c <= NS + 1; c++) begin
         tick();
         o[0][c] = outs(0);
         o[1][c] = outs(1);
      end
      for (int d = 0; d < 2; d++) begin
         lat = (d == 0) ? NS : lat1;
         first = -1; ndone = 0;
         for (int c = 1; c <= NS + 1; c++) begin
            if (o[d][c][3]) begin
               ndone++;
               if (first < 0) first = c;
            end
         end
         chk($sformatf("%s dut%0d done_cycle", nm, d), 32'(first), 32'(lat));
         chk($sformatf("%s dut%0d done_count", nm, d), 32'(ndone), 32'd1);
         chk($sformatf("%s dut%0d ready_back", nm, d), 32'(o[d][(lat < NS + 1) ? lat + 1 : NS + 1][4]), 32'd1);
         chk($sformatf("%s dut%0d flags", nm, d), 32'(o[d][NS + 1][2:0]), 32'(flags_of(res)));
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : main
      vec_t vt [12];
      logic [7:0] pa [2];
      logic [7:0] pb [2];
      logic [4:0] rec [2][18];
      logic [17:0] exp_done, act_done;
      int exp_r [18];
      int c, l, ndone;
      logic [7:0] ra, rb;
      logic rsm;

      vt[0]  = '{8'hA5, 8'h3C, 1'b0, 1, 1};
      vt[1]  = '{8'h5A, 8'h5A, 1'b0, 0, 4};
      vt[2]  = '{8'h80, 8'h7F, 1'b1, 2, 1};
      vt[3]  = '{8'h80, 8'h7F, 1'b0, 1, 1};
      vt[4]  = '{8'h00, 8'hFF, 1'b1, 1, 1};
      vt[5]  = '{8'h00, 8'hFF, 1'b0, 2, 1};
      vt[6]  = '{8'hC0, 8'h00, 1'b0, 1, 1};
      vt[7]  = '{8'h01, 8'h02, 1'b0, 2, 4};
      vt[8]  = '{8'h7F, 8'h80, 1'b1, 1, 1};
      vt[9]  = '{8'h12, 8'h13, 1'b0, 2, 4};
      vt[10] = '{8'hF0, 8'hF4, 1'b1, 2, 3};
      vt[11] = '{8'h5A, 8'h5A, 1'b1, 0, 4};

      // reset wins over a simultaneous start request
      drive(8'h00, 8'h00, 1'b0, 1'b1);
      rst = 1'b1;
      tick(); tick();
      chk("reset dut0", 32'(outs(0)), 32'b10000);
      chk("reset dut1", 32'(outs(1)), 32'b10000);
      drive(8'h00, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         run_cmp($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sm, vt[i].res, vt[i].lat_ee);
      end
      run_cmp("pre_abort", 8'hA5, 8'h3C, 1'b0, 1, 1);

      // abort mid-compare with cs_cmp high alongside rst
      drive(8'h01, 8'h02, 1'b0, 1'b1);
      tick();
      drive(8'h01, 8'h02, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      drive(8'h01, 8'h02, 1'b0, 1'b1);
      tick();
      chk("abort dut0", 32'(outs(0)), 32'b10000);
      chk("abort dut1", 32'(outs(1)), 32'b10000);
      tick();
      chk("abort_hold dut0", 32'(outs(0)), 32'b10000);
      chk("abort_hold dut1", 32'(outs(1)), 32'b10000);
      rst = 1'b0;
      tick();
      chk("post_abort capture0", 32'(if0.ready), 32'd0);
      chk("post_abort capture1", 32'(if1.ready), 32'd0);
      drive(8'h01, 8'h02, 1'b0, 1'b0);
      ndone = 0;
      for (int k = 0; k < NS + 1; k++) begin
         tick();
         ndone += int'(if0.done) + int'(if1.done);
      end
      chk("post_abort dones", 32'(ndone), 32'd2);
      chk("post_abort flags0", 32'(outs(0)), 32'b10001);
      chk("post_abort flags1", 32'(outs(1)), 32'b10001);

      // cs_cmp held high, operands toggled every cycle
      pa[0] = 8'h93; pb[0] = 8'h39;
      pa[1] = 8'h39; pb[1] = 8'h93;
      for (int i = 0; i < 18; i++) begin
         drive(pa[i % 2], pb[i % 2], 1'b0, 1'b1);
         tick();
         rec[0][i] = outs(0);
         rec[1][i] = outs(1);
      end
      drive(8'h00, 8'h00, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
         exp_done = '0;
         act_done = '0;
         for (int i = 0; i < 18; i++) begin
            exp_r[i] = -1;
            act_done[i] = rec[d][i][3];
         end
         c = 0;
         while (c < 18) begin
            l = model_lat(pa[c % 2], pb[c % 2], d == 1);
            if (c + l < 18) begin
               exp_done[c + l] = 1'b1;
               exp_r[c + l] = model_res(pa[c % 2], pb[c % 2], 1'b0);
            end
            c = c + l + 2;
         end
         chk($sformatf("stream dut%0d done_pattern", d), 32'(act_done), 32'(exp_done));
         for (int i = 0; i < 18; i++) begin
            if (exp_r[i] >= 0)
               chk($sformatf("stream dut%0d flags@%0d", d, i), 32'(rec[d][i][2:0]), 32'(flags_of(exp_r[i])));
         end
      end
      tick();

      // randomized operands against the reference model
      for (int i = 0; i < 60; i++) begin
         ra  = 8'($urandom);
         rb  = (i % 7 == 0) ? ra : 8'($urandom);
         rsm = 1'($urandom);
         run_cmp($sformatf("rnd%0d a=%0h b=%0h s=%0d", i, ra, rb, rsm), ra, rb, rsm,
                 model_res(ra, rb, rsm), model_lat(ra, rb, 1'b1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
